// File: rtl/lbf_pkg.sv
// Shared definitions for the byte-load fetch path: FSM states, byte-lane
// indices and the legal timeout window.
package lbf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OUT  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Physical lane numbers inside a 32-bit word; lane 0 is bits [7:0].
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_MIN = 2;
  localparam int unsigned TIMEOUT_MAX = 255;

  function automatic bit timeout_legal(input int unsigned timeout);
    return (timeout >= TIMEOUT_MIN) && (timeout <= TIMEOUT_MAX);
  endfunction

  // Big-endian numbering mirrors the lane index (3 - sel).
  function automatic logic [1:0] lane_index(input logic big_endian,
                                            input logic [1:0] sel);
    return big_endian ? ~sel : sel;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Combinational 32->8 byte-lane select; shared by the load and store paths.
module byte_lane_mux
  import lbf_pkg::*;
(
  input  logic        big_endian,
  input  logic [1:0]  sel,
  input  logic [31:0] word,
  output logic [7:0]  byte_sel
);

  logic [1:0] lane;

  always_comb begin
    lane = lane_index(big_endian, sel);
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    byte_sel = word[7:0];
    case (lane)
      LANE_B0: byte_sel = word[7:0];
      LANE_B1: byte_sel = word[15:8];
      LANE_B2: byte_sel = word[23:16];
      LANE_B3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

endmodule

// File: rtl/load_byte_fetch.sv
// Byte-load feeder: fetches the containing word over req/ack, selects the
// addressed lane and strobes it to the sign extender; aborts on timeout.
module load_byte_fetch
  import lbf_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        busy,
  output logic        err
);

  if (!timeout_legal(TIMEOUT)) begin : g_timeout_check
    $error("load_byte_fetch: TIMEOUT must lie in 2..255");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lane_byte;

  byte_lane_mux u_lane_mux (
    .big_endian (BIG_ENDIAN),
    .sel        (addr_q[1:0]),
    .word       (mem_rdata),
    .byte_sel   (lane_byte)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      byte_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= addr;
            cnt    <= '0;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (mem_ack) begin
            byte_out <= lane_byte;
            state    <= ST_OUT;
          end else if (cnt == CNT_LAST) begin
            state <= ST_ERR;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUT:  state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and strobes decode straight from the state register.
  assign mem_req    = (state == ST_REQ);
  assign byte_valid = (state == ST_OUT);
  assign err        = (state == ST_ERR);
  assign busy       = (state != ST_IDLE);
  assign mem_addr   = {addr_q[31:2], 2'b00};

endmodule

// File: doc/load_byte_fetch.md
# load_byte_fetch

Upstream feeder for the byte sign-extension stage (8-bit in, 32-bit out). It accepts a byte-load request with a byte address, fetches the containing 32-bit word over a req/ack memory handshake, and selects the addressed byte lane. It then presents the byte to the extender with a one-cycle valid strobe. It also bounds memory latency with a timeout and reports an error when the timeout expires.

## Interface
- TIMEOUT, 16: maximum cycles in REQ without `mem_ack` before abort; legal range 2..255.
- BIG_ENDIAN, 0: byte-lane order. 0 means addr[1:0]=0 selects rdata[7:0]. 1 means addr[1:0]=0 selects rdata[31:24].
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- addr  in  32  byte address; latched on accepted `start`.
- mem_req  out  1  memory request; held high through the whole REQ state.
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}; stable while `mem_req` is high.
- mem_ack  in  1  memory response; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  memory read word.
- byte_out  out  8  selected byte; drives the extender's 8-bit input.
- byte_valid  out  1  one-cycle strobe marking a new `byte_out`.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, REQ, OUT, ERR. Encoding is 2-bit binary, with IDLE=0.
- IDLE → REQ when `start`=1. The block latches `addr` and clears the timeout counter.
- REQ:
  - `mem_req`=1.
  - On `mem_ack`, capture the lane given by addr_q[1:0] and BIG_ENDIAN into `byte_out`, then go to OUT.
  - Otherwise, increment the counter.
  - When the counter reaches TIMEOUT-1 without an ack, go to ERR.
- OUT: `byte_valid`=1 for exactly one cycle, then IDLE.
- ERR: `err`=1 for exactly one cycle, then IDLE. `byte_out` is not updated.
- `start` while `busy`=1 is ignored; it is not queued.
- `mem_ack` outside REQ is ignored.
- If `mem_ack` arrives in the same cycle the counter hits TIMEOUT-1, the ack wins: the byte is captured and `err` stays low.
- Counter width is 8 bits. It saturates and never wraps, because the TIMEOUT range guarantees the limit is reached first.
- `byte_out` holds its last captured value between transactions.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and all outputs go to reset values. No `byte_valid` or `err` is emitted for the aborted transaction.

## Timing
- Reset values:
  - state=IDLE
  - `mem_req`=0, `mem_addr`=0, `byte_out`=0
  - `byte_valid`=0, `busy`=0, `err`=0
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- `start` accepted at edge N → `mem_req`=1 and `busy`=1 from cycle N+1.
- `mem_ack` sampled at edge K → `mem_req`=0 and `byte_valid`=1 in cycle K+1 → IDLE in cycle K+2.
- Minimum start-to-start period is 3 cycles (ack in the first REQ cycle).
- Timeout: when the first REQ cycle is R, `err` is high in cycle R+TIMEOUT and the block is back in IDLE at R+TIMEOUT+1.

## Structure
- Shared package `lbf_pkg`:
  - state localparams: ST_IDLE, ST_REQ, ST_OUT, ST_ERR
  - lane-index constants
  - TIMEOUT legality check constant
- One natural sub-module, `byte_lane_mux`: combinational 32→8 select on {BIG_ENDIAN, sel[1:0]}. It is reused later by the store path.
- Top level contains the FSM, the address register, the timeout counter, and the output registers.

## Test plan
- Reset, then `start` with `addr`=0x0000_1002 and BIG_ENDIAN=0. Memory acks after 3 cycles with rdata=0x8012_3456. Required: `mem_addr`=0x0000_1000, `byte_out`=0x12, and one `byte_valid` pulse 1 cycle after the ack.
- Four requests with addr[1:0]=0..3 and rdata=0x8040_2010, BIG_ENDIAN=0. Required bytes: 0x10, 0x20, 0x40, 0x80. The last byte feeds the extender, whose output must be 0xFFFF_FF80.
- TIMEOUT=4 with no ack. Required: `mem_req` high for 4 cycles, `err` pulsed once, `byte_valid` never asserted, `byte_out` unchanged.
- TIMEOUT=4 with ack in the 4th REQ cycle. Required: byte captured and `err`=0.
- `start` pulsed again during REQ, plus a stray `mem_ack` in IDLE. Required: both ignored; exactly one `byte_valid` per accepted `start`.
- `rst_n` driven low for 1 cycle mid-REQ. Required: `mem_req`, `busy`, and `byte_out` drop to 0 asynchronously, and no `byte_valid` or `err` follows.
